// File: rtl/sample_player.sv
// Sample playback sequencer: loads a ROM pointer, fetches bytes through a registered ROM
// read, and emits them to an 8-bit unsigned DAC once per period until a 0x00 end marker.
module sample_player (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cmd_addr,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [7:0]  rate_div,
  output logic [15:0] sample_addr_in,
  output logic [1:0]  sample_addr_wr,
  output logic        sample_inc,
  input  logic [7:0]  sample_data,
  output logic [7:0]  dac_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH0, FETCH1, WAIT, EMIT} state_t;

  localparam logic [7:0] SILENCE = 8'h80;
  localparam logic [7:0] MIN_PER = 8'd4;

  state_t     state, state_nx;
  logic [7:0] period;   // period latched at the last EMIT
  logic [7:0] cnt;      // cycles since the last EMIT
  logic       primed;   // set after LOAD: the first fetch skips WAIT
  logic       end_mark;

  assign end_mark       = (sample_data == 8'h00);
  assign sample_addr_wr = (state == LOAD) ? 2'b11 : 2'b00;
  assign busy           = (state != IDLE);

  always_comb begin
    state_nx   = state;
    sample_inc = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   state_nx = IDLE;
      LOAD:   state_nx = FETCH0;
      FETCH0: state_nx = FETCH1;
      FETCH1: state_nx = primed ? EMIT : WAIT;
      WAIT:   if (cnt >= period - 8'd1) state_nx = EMIT;
      EMIT: begin
        if (end_mark) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          sample_inc = 1'b1;
          state_nx   = FETCH0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Commands preempt the ROM strobes of the current cycle.
    if (cmd_stop) begin
      state_nx   = IDLE;
      sample_inc = 1'b0;
      done       = 1'b0;
    end else if (cmd_start) begin
      state_nx   = LOAD;
      sample_inc = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      dac_out        <= SILENCE;
      sample_addr_in <= 16'h0000;
      period         <= MIN_PER;
      cnt            <= 8'd0;
      primed         <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == EMIT) ? 8'd1 : cnt + 8'd1;
      if (state == LOAD)      primed <= 1'b1;
      else if (state == EMIT) primed <= 1'b0;
      if (cmd_stop) begin
        dac_out <= SILENCE;
      end else if (cmd_start) begin
        sample_addr_in <= cmd_addr;
      end else if (state == EMIT) begin
        dac_out <= end_mark ? SILENCE : sample_data;
        period  <= (rate_div < MIN_PER) ? MIN_PER : rate_div;
      end
    end
  end

endmodule

// File: tb/tb_sample_player.sv
// Randomized bench for sample_player: a ROM model plus a reference that predicts every
// cycle's strobes and DAC value from start time, byte list and per-EMIT period arithmetic.
module tb_sample_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cmd_addr;
  logic        cmd_start, cmd_stop;
  logic [7:0]  rate_div;
  logic [15:0] sample_addr_in;
  logic [1:0]  sample_addr_wr;
  logic        sample_inc;
  logic [7:0]  sample_data;
  logic [7:0]  dac_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_player dut (
    .clk(clk), .reset_n(reset_n), .cmd_addr(cmd_addr), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .rate_div(rate_div), .sample_addr_in(sample_addr_in),
    .sample_addr_wr(sample_addr_wr), .sample_inc(sample_inc), .sample_data(sample_data),
    .dac_out(dac_out), .busy(busy), .done(done)
  );

  // ROM: 18-bit pointer, data visible two cycles after the pointer changes.
  logic [7:0]  rom [0:262143];
  logic [17:0] ptr;
  logic [7:0]  d1;
  always @(posedge clk) begin
    if (sample_addr_wr == 2'b11) ptr <= {sample_addr_in[12:0], 5'b00000};
    else if (sample_inc)         ptr <= ptr + 18'd1;
    d1          <= rom[ptr];
    sample_data <= d1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int base_of(input logic [15:0] a);
    return {14'b0, a[12:0], 5'b00000};
  endfunction

  // One playback. Optional events (cycle numbers, 0 = none): stop, restart with addr2/b2,
  // reset, and start coinciding with stop. rate_fixed < 0 randomizes rate_div every cycle.
  task automatic play(input logic [15:0] addr, input logic [7:0] b1[$],
                      input logic [15:0] addr2, input logic [7:0] b2[$],
                      input int rate_fixed, input int stop_at, input int restart_at,
                      input int rst_at, input bit both);
    logic [7:0]  cur[$];
    logic [7:0]  e_dac, b;
    logic [15:0] cur_addr;
    int idx, next_emit, load_at, tail, p;
    bit alive, restarted, do_stop, do_rs, do_rst, emit_now, was_rst;
    b1.push_back(8'h00);
    b2.push_back(8'h00);
    foreach (b1[i]) rom[(base_of(addr) + i) % 262144] = b1[i];
    foreach (b2[i]) rom[(base_of(addr2) + i) % 262144] = b2[i];
    cur = b1; cur_addr = addr; idx = 0;
    load_at = 1; next_emit = 4; alive = 1; restarted = 0; tail = 0; was_rst = 0;
    e_dac = 8'h80;
    @(negedge clk);
    cmd_addr = addr; cmd_start = 1'b1; cmd_stop = 1'b0;
    rate_div = (rate_fixed >= 0) ? 8'(rate_fixed) : 8'($urandom_range(0, 9));
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      do_stop = (k == stop_at);
      do_rst  = (k == rst_at);
      do_rs   = (restart_at > 0) && (k >= restart_at) && !restarted && alive &&
                (k != next_emit) && !do_stop;
      cmd_stop  = do_stop;
      cmd_start = do_rs || (both && do_stop);
      cmd_addr  = do_rs ? addr2 : $urandom;
      reset_n   = !do_rst;
      rate_div  = (rate_fixed >= 0) ? 8'(rate_fixed) : 8'($urandom_range(0, 9));
      #1;
      emit_now = alive && (k == next_emit);
      b = emit_now ? cur[idx] : 8'h00;
      chk("addr_wr", 32'(sample_addr_wr), (alive && k == load_at) ? 32'd3 : 32'd0);
      chk("busy", 32'(busy), 32'(alive));
      chk("inc", 32'(sample_inc), 32'(emit_now && b != 8'h00 && !do_stop));
      chk("done", 32'(done), 32'(emit_now && b == 8'h00 && !do_stop));
      chk("dac", 32'(dac_out), 32'(e_dac));
      if (alive && k == load_at) chk("addr_in", 32'(sample_addr_in), 32'(cur_addr));
      if (was_rst) begin
        chk("rst_addr_in", 32'(sample_addr_in), 32'd0);
        was_rst = 0;
      end
      if (do_rst) begin
        alive = 0; e_dac = 8'h80; was_rst = 1;
      end else if (do_stop) begin
        alive = 0; e_dac = 8'h80;
      end else if (do_rs) begin
        restarted = 1; cur = b2; idx = 0; cur_addr = addr2;
        load_at = k + 1; next_emit = k + 4;
      end else if (emit_now) begin
        if (b == 8'h00) begin
          alive = 0; e_dac = 8'h80;
        end else begin
          e_dac = b; idx++;
          p = (int'(rate_div) < 4) ? 4 : int'(rate_div);
          next_emit = k + p;
        end
      end
      if (!alive) tail++;
      if (tail > 3) break;
    end
    chk("timeout", 32'(alive), 32'd0);
    reset_n = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0;
    foreach (b1[i]) rom[(base_of(addr) + i) % 262144] = 8'h00;
    foreach (b2[i]) rom[(base_of(addr2) + i) % 262144] = 8'h00;
  endtask

  function automatic void rand_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(1, 255)));
  endfunction

  logic [7:0]  qa[$], qb[$], qe[$];
  logic [15:0] a;

  initial begin
    for (int i = 0; i < 262144; i++) rom[i] = 8'h00;
    qe = {};
    reset_n = 1'b0; cmd_addr = 16'h0; cmd_start = 1'b0; cmd_stop = 1'b0; rate_div = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_dac", 32'(dac_out), 32'h80);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr", 32'(sample_addr_wr), 32'd0);
    chk("reset_inc", 32'(sample_inc), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_addr_in", 32'(sample_addr_in), 32'd0);
    reset_n = 1'b1;

    // 0x10, 0x20 at ROM 0x02000, period 6
    qa = {8'h10, 8'h20};
    play(16'h0100, qa, 16'h0, qe, 6, 0, 0, 0, 1'b0);
    // short rate clamps to 4
    rand_bytes(qa, 5);
    play(16'h0235, qa, 16'h0, qe, 1, 0, 0, 0, 1'b0);
    // random lengths, addresses (including ignored upper bits) and per-cycle rates
    for (int r = 0; r < 20; r++) begin
      rand_bytes(qa, $urandom_range(0, 5));
      a = 16'($urandom);
      play(a, qa, 16'h0, qe, -1, 0, 0, 0, 1'b0);
    end
    // stop in the first WAIT
    rand_bytes(qa, 4);
    play(16'h0410, qa, 16'h0, qe, -1, 7, 0, 0, 1'b0);
    // restart to a new address mid-playback
    rand_bytes(qa, 5); rand_bytes(qb, 3);
    play(16'h0520, qa, 16'h0777, qb, -1, 0, 6, 0, 1'b0);
    // start and stop together
    rand_bytes(qa, 4);
    play(16'h0630, qa, 16'h0, qe, -1, 5, 0, 0, 1'b1);
    // reset during FETCH1
    rand_bytes(qa, 4);
    play(16'h0740, qa, 16'h0, qe, -1, 0, 0, 3, 1'b0);
    // empty sample
    play(16'h0850, qe, 16'h0, qe, -1, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
